// File: rtl/secuenciador_corrimiento.sv
// Multi-cycle shift sequencer. A request shifts a value by a total amount.
// The sequencer splits that amount into steps of at most STEP_MAX and
// drives an external combinational shift unit once per RUN cycle.
// The result is held in DONE until the consumer takes it.
module secuenciador_corrimiento #(
  parameter int N        = 8,
  parameter int STEP_MAX = 3,
  parameter int AW       = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_op,
  input  logic signed [N-1:0]  req_data,
  input  logic [AW-1:0]        req_amount,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic signed [N-1:0]  res_data,
  output logic                 busy,
  output logic [N-1:0]         su_f,
  output logic [2:0]           su_h,
  output logic [(N-1)/2:0]     su_d,
  input  logic [N-1:0]         su_s
);

  localparam int DW = (N - 1) / 2 + 1;
  localparam logic [AW-1:0] STEP_A = AW'(STEP_MAX);

  localparam logic [2:0] OP_TRANSFER = 3'b000;
  localparam logic [2:0] OP_ZERO     = 3'b011;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [AW-1:0] rem_q, rem_d;
  logic [2:0]    op_q, op_d;
  logic [AW-1:0] step;
  logic [AW-1:0] rem_left;
  logic          single_step;

  // State, accumulator, remaining amount and latched opcode registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      op_q    <= 3'b000;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
    end
  end

  // Next-state logic, step sizing and shift-unit drive; clr overrides everything.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    rem_d       = rem_q;
    op_d        = op_q;
    step        = (rem_q < STEP_A) ? rem_q : STEP_A;
    rem_left    = rem_q - step;
    single_step = (op_q == OP_TRANSFER) || (op_q == OP_ZERO);
    req_ready   = (state_q == IDLE);
    res_valid   = (state_q == DONE);
    busy        = (state_q == RUN);
    su_f        = acc_q;
    su_h        = 3'b000;
    su_d        = '0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          acc_d   = req_data;
          rem_d   = req_amount;
          state_d = RUN;
        end
      end
      RUN: begin
        su_h  = op_q;
        su_d  = DW'(step);
        acc_d = su_s;
        if (single_step || (rem_left == '0)) begin
          rem_d   = '0;
          state_d = DONE;
        end else begin
          rem_d = rem_left;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (clr) begin
      state_d = IDLE;
      acc_d   = acc_q;
      rem_d   = rem_q;
      op_d    = op_q;
    end
  end

  assign res_data = acc_q;

endmodule

// File: tb/tb_secuenciador_corrimiento.sv
// Self-checking bench for secuenciador_corrimiento with a behavioural shift unit.
module tb_secuenciador_corrimiento;

  localparam int N        = 8;
  localparam int STEP_MAX = 3;
  localparam int AW       = 4;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b0;
  logic       clr        = 1'b0;
  logic       req_valid  = 1'b0;
  logic       res_ready  = 1'b0;
  logic [2:0] req_op     = 3'b000;
  logic [7:0] req_data   = 8'h00;
  logic [3:0] req_amount = 4'h0;
  logic       req_ready;
  logic       res_valid;
  logic       busy;
  logic [7:0] res_data;
  logic [7:0] su_f;
  logic [7:0] su_s;
  logic [2:0] su_h;
  logic [3:0] su_d;

  int pass_count  = 0;
  int check_count = 0;

  typedef struct {
    logic [2:0] op;
    logic [7:0] data;
    logic [3:0] amount;
    logic [7:0] exp_data;
    int         exp_steps;
  } vec_t;

  typedef struct {
    logic [2:0] op;
    logic [3:0] amount;
    logic [7:0] exp_data;
    int         exp_steps;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[15];

  secuenciador_corrimiento #(
    .N(N),
    .STEP_MAX(STEP_MAX),
    .AW(AW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clr(clr),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op(req_op),
    .req_data(req_data),
    .req_amount(req_amount),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data(res_data),
    .busy(busy),
    .su_f(su_f),
    .su_h(su_h),
    .su_d(su_d),
    .su_s(su_s)
  );

  // Clock generator, 10 time-unit period.
  always #5 clk = ~clk;

  // Behavioural model of the external combinational shift unit.
  function automatic logic [7:0] su_model(input logic [7:0] f, input logic [2:0] h,
                                          input logic [3:0] d);
    logic [7:0]        r;
    logic signed [7:0] fs;
    r  = f;
    fs = f;
    case (h)
      3'b000: r = f;
      3'b001: r = f << d;
      3'b010: r = f >> d;
      3'b011: r = 8'h00;
      3'b100: for (int i = 0; i < 16; i++) if (i < int'(d)) r = {r[6:0], r[7]};
      3'b101: for (int i = 0; i < 16; i++) if (i < int'(d)) r = {r[0], r[7:1]};
      3'b110: r = f << d;
      default: r = fs >>> d;
    endcase
    return r;
  endfunction

  assign su_s = su_model(su_f, su_h, su_d);

  // Expected step size for RUN cycle idx of a request with the given amount.
  function automatic logic [31:0] exp_d(input int amount, input int idx);
    int rem;
    rem = amount;
    for (int i = 0; i < idx; i++) rem -= (rem < STEP_MAX) ? rem : STEP_MAX;
    return (rem < STEP_MAX) ? rem : STEP_MAX;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Drives a request at the current (negedge) time and waits for the accept edge.
  task automatic start_txn(input logic [2:0] op, input logic [7:0] data,
                           input logic [3:0] amt, input logic [7:0] exp_data,
                           input int exp_steps);
    req_valid  = 1'b1;
    req_op     = op;
    req_data   = data;
    req_amount = amt;
    check_output("req_ready_at_accept", req_ready, 1);
    sb.push_back('{op, amt, exp_data, exp_steps});
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_op     = 3'($urandom);
    req_data   = 8'($urandom);
    req_amount = 4'($urandom);
  endtask

  // Monitors RUN cycles, compares the result against the scoreboard and handshakes.
  task automatic finish_txn(input int stall, input bit handshake);
    int   waits;
    int   runs;
    bit   got;
    exp_t e;
    waits = 0;
    runs  = 0;
    got   = 1'b0;
    while (!got && waits < 40) begin
      @(negedge clk);
      waits++;
      if (res_valid) got = 1'b1;
      else if (busy) begin
        check_output("su_d_step", su_d, exp_d(sb[0].amount, runs));
        check_output("su_h_op", su_h, sb[0].op);
        runs++;
      end
    end
    e = sb.pop_front();
    if (!got) begin
      check_output("res_valid_timeout", 0, 1);
      return;
    end
    check_output("res_data", res_data, e.exp_data);
    check_output("run_cycles", runs, e.exp_steps);
    check_output("latency", waits, e.exp_steps + 1);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check_output("stall_res_valid", res_valid, 1);
      check_output("stall_res_data", res_data, e.exp_data);
    end
    if (handshake) begin
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    @(negedge clk);
    start_txn(v.op, v.data, v.amount, v.exp_data, v.exp_steps);
    finish_txn(0, 1);
  endtask

  // Main test sequence.
  initial begin
    bit seen_valid;
    vecs[0]  = '{3'b001, 8'h01, 4'd5,  8'h20, 2};
    vecs[1]  = '{3'b111, 8'h80, 4'd9,  8'hFF, 3};
    vecs[2]  = '{3'b010, 8'h80, 4'd9,  8'h00, 3};
    vecs[3]  = '{3'b101, 8'h81, 4'd4,  8'h18, 2};
    vecs[4]  = '{3'b100, 8'h81, 4'd1,  8'h03, 1};
    vecs[5]  = '{3'b000, 8'h5A, 4'd7,  8'h5A, 1};
    vecs[6]  = '{3'b011, 8'h5A, 4'd7,  8'h00, 1};
    vecs[7]  = '{3'b110, 8'hC3, 4'd2,  8'h0C, 1};
    vecs[8]  = '{3'b111, 8'h40, 4'd3,  8'h08, 1};
    vecs[9]  = '{3'b001, 8'hA5, 4'd0,  8'hA5, 1};
    vecs[10] = '{3'b100, 8'h81, 4'd15, 8'hC0, 5};
    vecs[11] = '{3'b010, 8'hFF, 4'd8,  8'h00, 3};
    vecs[12] = '{3'b101, 8'h01, 4'd6,  8'h04, 2};
    vecs[13] = '{3'b111, 8'h7F, 4'd6,  8'h01, 2};
    vecs[14] = '{3'b001, 8'h01, 4'd7,  8'h80, 3};

    #12;
    check_output("rst_req_ready", req_ready, 1);
    check_output("rst_res_valid", res_valid, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_res_data", res_data, 0);
    check_output("rst_su_f", su_f, 0);
    check_output("rst_su_h", su_h, 0);
    check_output("rst_su_d", su_d, 0);

    @(negedge clk);
    rst_n = 1'b1;
    start_txn(vecs[0].op, vecs[0].data, vecs[0].amount, vecs[0].exp_data, vecs[0].exp_steps);
    finish_txn(0, 1);

    for (int i = 1; i < 15; i++) apply_stimulus(vecs[i]);

    @(negedge clk);
    start_txn(3'b100, 8'h81, 4'd1, 8'h03, 1);
    finish_txn(4, 0);
    req_valid  = 1'b1;
    req_op     = 3'b001;
    req_data   = 8'h01;
    req_amount = 4'd5;
    res_ready  = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    @(negedge clk);
    check_output("no_accept_on_exit_busy", busy, 0);
    check_output("no_accept_on_exit_valid", res_valid, 0);
    start_txn(3'b001, 8'h01, 4'd5, 8'h20, 2);
    finish_txn(0, 1);

    @(negedge clk);
    start_txn(3'b001, 8'h01, 4'd8, 8'h00, 3);
    @(negedge clk);
    check_output("clr_run1_busy", busy, 1);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    void'(sb.pop_front());
    check_output("clr_busy", busy, 0);
    check_output("clr_req_ready", req_ready, 1);
    seen_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (res_valid) seen_valid = 1'b1;
    end
    check_output("clr_no_res_valid", seen_valid, 0);
    apply_stimulus(vecs[3]);

    @(negedge clk);
    clr        = 1'b1;
    req_valid  = 1'b1;
    req_op     = 3'b001;
    req_data   = 8'h01;
    req_amount = 4'd1;
    @(posedge clk);
    #1;
    clr       = 1'b0;
    req_valid = 1'b0;
    check_output("clr_beats_req_valid", busy, 0);

    @(negedge clk);
    start_txn(3'b111, 8'h80, 4'd9, 8'hFF, 3);
    @(negedge clk);
    check_output("rst_run_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    void'(sb.pop_front());
    check_output("midrst_busy", busy, 0);
    check_output("midrst_req_ready", req_ready, 1);
    check_output("midrst_res_valid", res_valid, 0);
    check_output("midrst_res_data", res_data, 0);
    check_output("midrst_su_f", su_f, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (res_valid) seen_valid = 1'b1;
    end
    check_output("midrst_no_res_valid", seen_valid, 0);
    apply_stimulus(vecs[0]);

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/secuenciador_corrimiento.md
SECUENCIADOR_CORRIMIENTO -- requirements
Module: secuenciador_corrimiento

Interface
REQ-001 SHALL have parameter N, default 8: data width of the shift datapath.
REQ-002 SHALL have parameter STEP_MAX, default 3: largest shift amount issued per cycle; legal range 1..min(N-1, 2**((N-1)/2+1)-1).
REQ-003 SHALL have parameter AW, default 4: width of the total shift amount.
REQ-004 One clock; reset is asynchronous and active-low: clk input 1 (rising-edge clock) and rst_n input 1 (asynchronous active-low reset).
REQ-005 clr input 1: synchronous abort.
REQ-006 req_valid input 1; req_ready output 1; req_op input 3 (shift-unit operation code); req_data input N signed; req_amount input AW (total shift).
REQ-007 res_valid output 1; res_ready input 1; res_data output N signed.
REQ-008 busy output 1: high in RUN.
REQ-009 su_f output N, su_h output 3 and su_d output (N-1)/2+1 drive the external shift unit; su_s input N is its combinational result.

Function
REQ-010 Operation codes match the shift unit: 000 transfer, 001 shl, 010 shr, 011 zero, 100 rol, 101 ror, 110 asl, 111 asr.
REQ-011 States SHALL be IDLE, RUN and DONE.
REQ-012 req_ready SHALL be 1 only in IDLE.
REQ-013 IDLE: on req_valid=1, SHALL latch op, data into acc and amount into rem, then enter RUN.
REQ-014 RUN, each cycle: d = min(rem, STEP_MAX); su_f=acc, su_h=op, su_d=d; at the edge acc<=su_s and rem<=rem-d.
REQ-015 RUN to DONE when rem-d==0; otherwise SHALL stay in RUN.
REQ-016 Ops 000 and 011, and req_amount=0, SHALL use exactly one RUN cycle with su_d=rem (clamped as in REQ-014; 0 when amount is 0); 000/011 then force rem to 0.
REQ-017 Number of RUN cycles = max(1, ceil(amount/STEP_MAX)) for shift ops.
REQ-018 Latency: accept at edge k, res_valid=1 after edge k+steps.
REQ-019 Result SHALL equal a single shift by the full amount: shl/shr/asl give zeros when amount>=N; asr gives sign fill; rol/ror rotate by amount mod N.
REQ-020 DONE: res_valid=1 and res_data=acc, held stable until res_ready=1; on res_ready=1, return to IDLE at that edge.
REQ-021 A new request SHALL NOT be accepted in the cycle DONE exits; it is accepted one cycle later in IDLE.
REQ-022 Outside RUN, su_h=000, su_d=0 and su_f=acc.
REQ-023 clr=1 SHALL force IDLE at the next edge from any state and discard the result; clr has priority over req_valid and res_ready.
REQ-024 res_data SHALL equal acc in all states; it is only meaningful while res_valid=1.
REQ-025 req_data, req_op and req_amount SHALL be ignored while req_ready=0.

Reset
REQ-026 rst_n=0 SHALL asynchronously force IDLE, acc=0, rem=0 and op=000.
REQ-027 Outputs during reset: req_ready=1, res_valid=0, busy=0, res_data=0, su_f=0, su_h=000, su_d=0.
REQ-028 Reset mid-RUN or mid-DONE SHALL drop the operation with no res_valid pulse.
REQ-029 After rst_n deasserts, the first rising edge SHALL accept a request.

Verification (N=8, STEP_MAX=3, AW=4)
REQ-030 shl, data 8'h01, amount 5 -> su_d sequence 3,2; res_data 8'h20; res_valid after edge k+2.
REQ-031 asr, data 8'h80, amount 9 -> three RUN cycles; res_data 8'hFF. Then shr, data 8'h80, amount 9 -> res_data 8'h00.
REQ-032 ror, data 8'h81, amount 4 -> su_d 3,1; res_data 8'h18. Then rol, data 8'h81, amount 1 -> res_data 8'h03 after one RUN cycle.
REQ-033 Transfer, data 8'h5A, amount 7 -> one RUN cycle; res_data 8'h5A. Then zero op -> res_data 8'h00.
REQ-034 Backpressure: res_ready=0 for 4 cycles in DONE -> res_valid and res_data stable; req_valid held high is accepted only one cycle after the res_ready handshake.
REQ-035 clr asserted in the 2nd RUN cycle, and separately rst_n pulsed low in RUN -> IDLE, no res_valid pulse, req_ready=1, next request completes correctly.
